speicher_arbiter: RTL
=====================

Name: speicher_arbiter

Overview:
- Shares one external memory port between the CPU's instruction-fetch and data (load/store) interfaces.
- Sits between the CPU bus signals (instruction address, data address, read/write strobes and done pulses) and the single-ported memory/bus controller.
- Round-robin arbitration, registered memory strobes, one-cycle done pulses, optional bus timeout with error flag.

Parameters:
- ADRESS_BREITE, 32, address width on all sides
- DATEN_BREITE, 32, data width
- TIMEOUT, 255, max cycles waiting for MemBereit; 0 disables timeout

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- InstruktionAdresse  in  ADRESS_BREITE  fetch address
- LeseInstruktion  in  1  fetch request (level)
- InstruktionGeladen  out  1  fetch done, 1-cycle pulse
- Instruktion  out  DATEN_BREITE  fetched word, registered
- DatenAdresse  in  ADRESS_BREITE  load/store address
- DatenRaus  in  DATEN_BREITE  store data
- LeseDaten  in  1  load request (level)
- SchreibeDaten  in  1  store request (level)
- DatenGeladen  out  1  load done, 1-cycle pulse
- DatenGespeichert  out  1  store done, 1-cycle pulse
- DatenRein  out  DATEN_BREITE  loaded word, registered
- MemAdresse  out  ADRESS_BREITE  memory address
- MemSchreibDaten  out  DATEN_BREITE  memory write data
- MemLesen  out  1  memory read strobe (level)
- MemSchreiben  out  1  memory write strobe (level)
- MemBereit  in  1  memory completes current access this cycle
- MemLeseDaten  in  DATEN_BREITE  read data, valid when MemBereit=1
- BusFehler  out  1  sticky timeout flag

Behaviour:
- Reset (sync, has priority over everything, also mid-access): state LEERLAUF; all outputs 0; last-granted bit = data; timeout counter 0. In-flight access is abandoned, no done pulse.
- States: LEERLAUF, ZUGRIFF, FERTIG.
- LEERLAUF: sample requests. Instruction request = LeseInstruktion; data request = LeseDaten | SchreibeDaten. Only one pending -> grant it. Both pending -> grant the one NOT granted last (round-robin). On grant: latch address (and store data), set MemLesen or MemSchreiben, go ZUGRIFF next edge. Strobe rises one cycle after request first seen.
- Data grant with LeseDaten and SchreibeDaten both high: store wins, treated as write only; only DatenGespeichert pulses.
- ZUGRIFF: MemAdresse/MemSchreibDaten/strobe held stable. MemBereit=1 -> capture MemLeseDaten into Instruktion or DatenRein (reads only), drop strobe, go FERTIG. Stores leave DatenRein unchanged.
- FERTIG (exactly one cycle): matching done output = 1; update last-granted bit; go LEERLAUF.
- Minimum latency: request seen at cycle t, strobe at t+1, MemBereit at t+1 -> done pulse at t+2; the next request is accepted at t+3.
- Requester must drop its request by the edge ending its FERTIG cycle; a request still high in the following LEERLAUF is a new access.
- Instruktion / DatenRein hold their last value until overwritten by the next completed read of that type.
- Timeout (TIMEOUT>0): counter clears on entering ZUGRIFF and increments each ZUGRIFF cycle without MemBereit. When it reaches TIMEOUT: drop strobe, set BusFehler, write 0 into the read-data register (reads), go FERTIG (done still pulses so the CPU cannot hang). BusFehler clears only on Reset.
- MemBereit outside ZUGRIFF is ignored.
- Request changes during ZUGRIFF/FERTIG do not affect the current access.

Test Plan:
- Reset, then LeseInstruktion=1 at addr 0x40, MemBereit=1 one cycle after MemLesen rises with data 0xDEADBEEF -> MemAdresse=0x40; InstruktionGeladen pulses 2 cycles after request; Instruktion=0xDEADBEEF.
- Store to 0x100 with data 0x12345678, memory waits 3 cycles -> MemSchreiben high 4 cycles with stable addr/data; DatenGespeichert single pulse; DatenRein unchanged.
- Fetch and load raised in the same cycle after reset (last = data) -> fetch is served first, then the load; repeat -> order alternates between the two.
- TIMEOUT=4, load, MemBereit never asserted -> strobe drops after 4 cycles; DatenGeladen pulses; DatenRein=0; BusFehler=1 and stays 1 until Reset.
- Reset asserted while in ZUGRIFF -> next cycle strobes=0, no done pulse, BusFehler=0; new fetch then completes normally.
- LeseDaten and SchreibeDaten both high -> only MemSchreiben asserted; only DatenGespeichert pulses.

Source files
------------

// File: rtl/speicher_arbiter.sv
// rtl/speicher_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data
module speicher_arbiter #(
   parameter int ADRESS_BREITE = 32,
   parameter int DATEN_BREITE  = 32,
   parameter int TIMEOUT       = 255
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [ADRESS_BREITE-1:0] InstruktionAdresse,
   input  logic                     LeseInstruktion,
   output logic                     InstruktionGeladen,
   output logic [DATEN_BREITE-1:0]  Instruktion,
   input  logic [ADRESS_BREITE-1:0] DatenAdresse,
   input  logic [DATEN_BREITE-1:0]  DatenRaus,
   input  logic                     LeseDaten,
   input  logic                     SchreibeDaten,
   output logic                     DatenGeladen,
   output logic                     DatenGespeichert,
   output logic [DATEN_BREITE-1:0]  DatenRein,
   output logic [ADRESS_BREITE-1:0] MemAdresse,
   output logic [DATEN_BREITE-1:0]  MemSchreibDaten,
   output logic                     MemLesen,
   output logic                     MemSchreiben,
   input  logic                     MemBereit,
   input  logic [DATEN_BREITE-1:0]  MemLeseDaten,
   output logic                     BusFehler
);
   typedef enum logic [1:0] {LEERLAUF, ZUGRIFF, FERTIG} zustand_t;

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LETZTER = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   zustand_t                 zustand_q;
   logic                     daten_q;          // grant of the running access: 1 = data port
   logic                     schreib_q;
   logic                     zuletzt_daten_q;
   logic [CW-1:0]            zaehler_q;
   logic [ADRESS_BREITE-1:0] mem_adresse_q;
   logic [DATEN_BREITE-1:0]  mem_schreib_daten_q;
   logic                     mem_lesen_q;
   logic                     mem_schreiben_q;
   logic [DATEN_BREITE-1:0]  instruktion_q;
   logic [DATEN_BREITE-1:0]  daten_rein_q;
   logic                     instr_geladen_q;
   logic                     daten_geladen_q;
   logic                     daten_gespeichert_q;
   logic                     bus_fehler_q;

   logic instr_anf;
   logic daten_anf;
   logic waehle_daten;
   logic schreib_grant;
   logic zeitablauf;

   assign instr_anf     = LeseInstruktion;
   assign daten_anf     = LeseDaten | SchreibeDaten;
   assign waehle_daten  = daten_anf & (~instr_anf | ~zuletzt_daten_q);
   assign schreib_grant = waehle_daten & SchreibeDaten;
   assign zeitablauf    = (TIMEOUT > 0) && (zaehler_q == LETZTER);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         zustand_q           <= LEERLAUF;
         daten_q             <= 1'b0;
         schreib_q           <= 1'b0;
         zuletzt_daten_q     <= 1'b1;
         zaehler_q           <= '0;
         mem_adresse_q       <= '0;
         mem_schreib_daten_q <= '0;
         mem_lesen_q         <= 1'b0;
         mem_schreiben_q     <= 1'b0;
         instruktion_q       <= '0;
         daten_rein_q        <= '0;
         instr_geladen_q     <= 1'b0;
         daten_geladen_q     <= 1'b0;
         daten_gespeichert_q <= 1'b0;
         bus_fehler_q        <= 1'b0;
      end else begin
         instr_geladen_q     <= 1'b0;
         daten_geladen_q     <= 1'b0;
         daten_gespeichert_q <= 1'b0;
         case (zustand_q)
            LEERLAUF: begin
               if (instr_anf || daten_anf) begin
                  daten_q         <= waehle_daten;
                  schreib_q       <= schreib_grant;
                  mem_adresse_q   <= waehle_daten ? DatenAdresse : InstruktionAdresse;
                  mem_lesen_q     <= ~schreib_grant;
                  mem_schreiben_q <= schreib_grant;
                  zaehler_q       <= '0;
                  zustand_q       <= ZUGRIFF;
                  if (schreib_grant) mem_schreib_daten_q <= DatenRaus;
               end
            end
            ZUGRIFF: begin
               // a timed-out read still completes, returning zero, so the CPU never stalls
               if (MemBereit || zeitablauf) begin
                  mem_lesen_q         <= 1'b0;
                  mem_schreiben_q     <= 1'b0;
                  instr_geladen_q     <= ~daten_q;
                  daten_geladen_q     <= daten_q & ~schreib_q;
                  daten_gespeichert_q <= daten_q & schreib_q;
                  zustand_q           <= FERTIG;
                  if (!MemBereit) bus_fehler_q <= 1'b1;
                  if (!schreib_q) begin
                     if (daten_q) daten_rein_q  <= MemBereit ? MemLeseDaten : '0;
                     else         instruktion_q <= MemBereit ? MemLeseDaten : '0;
                  end
               end else begin
                  zaehler_q <= zaehler_q + CW'(1);
               end
            end
            FERTIG: begin
               zuletzt_daten_q <= daten_q;
               zustand_q       <= LEERLAUF;
            end
            default: zustand_q <= LEERLAUF;
         endcase
      end
   end

   assign InstruktionGeladen = instr_geladen_q;
   assign Instruktion        = instruktion_q;
   assign DatenGeladen       = daten_geladen_q;
   assign DatenGespeichert   = daten_gespeichert_q;
   assign DatenRein          = daten_rein_q;
   assign MemAdresse         = mem_adresse_q;
   assign MemSchreibDaten    = mem_schreib_daten_q;
   assign MemLesen           = mem_lesen_q;
   assign MemSchreiben       = mem_schreiben_q;
   assign BusFehler          = bus_fehler_q;
endmodule
